field_init_loader: RTL
======================

// Module: field_init_loader
// PURPOSE
// Consumer of field_rom. Starting on i_start, scans the initial configuration stored in field_rom
// in raster order (y outer, x inner) and streams every cell as a write into the live field memory.
// Registers the ROM read data, honours valid/ready backpressure from the field memory, and counts
// live cells. Sits between field_rom and the field RAM / cell array of the Game of Life core.
// PARAMETERS
// FIELD_W  3  field width in cells, >=2, power of two not required
// FIELD_H  3  field height in cells, >=2, power of two not required
// X_ADR_SIZE  $clog2(FIELD_W)  x address width (derived)
// Y_ADR_SIZE  $clog2(FIELD_H)  y address width (derived)
// CNT_SIZE  $clog2(FIELD_W*FIELD_H+1)  live-count width (derived)
// PORTS
// i_clk  in  1  clock, rising edge
// i_rst_n  in  1  asynchronous active-low reset
// i_start  in  1  start load, sampled only in IDLE
// o_busy  out  1  high while state != IDLE
// o_done  out  1  one-cycle pulse after the last write is accepted
// o_rom_x_adr  out  X_ADR_SIZE  scan x address to field_rom (driven from scan counter reg)
// o_rom_y_adr  out  Y_ADR_SIZE  scan y address to field_rom
// i_rom_cell_state  in  1  field_rom data, combinational from o_rom_*_adr
// o_wr_valid  out  1  write request valid
// i_wr_ready  in  1  field memory accepts; transfer = o_wr_valid & i_wr_ready
// o_wr_x_adr  out  X_ADR_SIZE  write x address
// o_wr_y_adr  out  Y_ADR_SIZE  write y address
// o_wr_data  out  1  cell state to write (1 = alive)
// o_live_cnt  out  CNT_SIZE  number of alive cells accepted in the current/last load
// BEHAVIOUR
// - Reset (async, i_rst_n=0): state=IDLE, scan x/y=0, o_wr_valid=0, o_wr_x/y_adr=0,
//   o_wr_data=0, o_live_cnt=0, o_done=0, o_busy=0. Reset mid-load aborts; no further writes.
// - FSM: IDLE -> LOAD on i_start; LOAD -> DONE when scan exhausted and last write accepted;
//   DONE -> IDLE unconditionally next cycle. o_done = (state==DONE); o_busy = (state!=IDLE).
// - i_start in LOAD/DONE is ignored (no restart, no counter change).
// - Entering LOAD: scan (x,y)=(0,0), o_live_cnt cleared to 0, scan_end flag cleared.
// - In LOAD, output register loads when (!o_wr_valid | i_wr_ready) and !scan_end:
//   o_wr_valid<=1, o_wr_x/y_adr<=scan x/y, o_wr_data<=i_rom_cell_state; scan advances:
//   x==FIELD_W-1 -> x=0, y++; at (FIELD_W-1,FIELD_H-1) set scan_end, counters hold.
//   x/y never take values >= FIELD_W/FIELD_H.
// - Accepted write clears o_wr_valid if nothing new loads the same cycle.
// - While o_wr_valid & !i_wr_ready: o_wr_* and scan counters hold stable (no drop, no dup).
// - o_live_cnt increments by 1 on each transfer with o_wr_data=1; saturation impossible by width;
//   value holds after DONE until next start.
// - Latency: i_start at edge 0 -> first o_wr_valid after edge 1 (cell 0,0). With i_wr_ready=1
//   constantly: one write per cycle, N=FIELD_W*FIELD_H writes, o_done high after edge N+1,
//   o_busy low after edge N+2. Each stall cycle delays everything by one cycle.
// - Exactly N transfers per load, in raster order, each address exactly once.
// TESTING
// - 3x3, ready=1, start pulse: 9 transfers at cycles 1..9 with addresses (0,0),(1,0),(2,0),(0,1)..(2,2),
//   data equal to direct field_rom reads; o_done pulse at cycle 10; o_busy low from cycle 11.
// - 3x3, ready low cycles 4..6: write #4 (0,1) held stable 3 cycles, no duplicates; o_done at cycle 13.
// - o_live_cnt at o_done equals number of 1s in scanned ROM image (e.g. 3 for vertical blinker).
// - i_start re-asserted at cycle 4 during load: ignored, still exactly 9 writes, single o_done.
// - i_rst_n low at cycle 5: o_wr_valid=0, o_busy=0, o_live_cnt=0 immediately; fresh start reloads from (0,0).
// - FIELD_W=5,FIELD_H=3: x sequence 0..4 then wrap, never 5..7; 15 transfers; o_done at cycle 16.

Source files
------------

// File: rtl/field_init_loader.sv
// Streams the initial field image from field_rom into the live field memory in raster order,
// one registered valid/ready write per cell, while counting the live cells accepted.
module field_init_loader #(
  parameter int FIELD_W    = 3,
  parameter int FIELD_H    = 3,
  parameter int X_ADR_SIZE = $clog2(FIELD_W),
  parameter int Y_ADR_SIZE = $clog2(FIELD_H),
  parameter int CNT_SIZE   = $clog2(FIELD_W * FIELD_H + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [X_ADR_SIZE-1:0] o_rom_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_rom_y_adr,
  input  logic                  i_rom_cell_state,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  output logic [X_ADR_SIZE-1:0] o_wr_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_wr_y_adr,
  output logic                  o_wr_data,
  output logic [CNT_SIZE-1:0]   o_live_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  state_t                  state, state_nxt;
  logic [X_ADR_SIZE-1:0]   scan_x;
  logic [Y_ADR_SIZE-1:0]   scan_y;
  logic                    scan_end;
  logic                    xfer;
  logic                    load_en;

  assign xfer        = o_wr_valid & i_wr_ready;
  // The output register refills whenever it is empty or being drained this cycle.
  assign load_en     = (state == LOAD) & (~o_wr_valid | i_wr_ready) & ~scan_end;
  assign o_rom_x_adr = scan_x;
  assign o_rom_y_adr = scan_y;
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = LOAD;
      LOAD:    if (scan_end && xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scan_x     <= '0;
      scan_y     <= '0;
      scan_end   <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_x_adr <= '0;
      o_wr_y_adr <= '0;
      o_wr_data  <= 1'b0;
      o_live_cnt <= '0;
    end else begin
      if (state == IDLE && i_start) begin
        scan_x     <= '0;
        scan_y     <= '0;
        scan_end   <= 1'b0;
        o_live_cnt <= '0;
      end
      if (state == LOAD) begin
        if (xfer && o_wr_data) begin
          o_live_cnt <= o_live_cnt + CNT_SIZE'(1);
        end
        if (load_en) begin
          o_wr_valid <= 1'b1;
          o_wr_x_adr <= scan_x;
          o_wr_y_adr <= scan_y;
          o_wr_data  <= i_rom_cell_state;
          // The last cell parks the counters and raises scan_end instead of wrapping.
          if (scan_x == X_LAST) begin
            if (scan_y == Y_LAST) begin
              scan_end <= 1'b1;
            end else begin
              scan_x <= '0;
              scan_y <= scan_y + Y_ADR_SIZE'(1);
            end
          end else begin
            scan_x <= scan_x + X_ADR_SIZE'(1);
          end
        end else if (xfer) begin
          o_wr_valid <= 1'b0;
        end
      end
    end
  end

endmodule
